mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory stage of the 5-stage 16-bit pipeline, sitting between the EX/MEM pipeline register and the writeback mux.
- Takes the EXMem_* control and data bundle and drives a multi-cycle data memory through a request/done handshake.
- Freezes the upstream pipeline while an access is outstanding.
- Contains the MEM/WB pipeline register, which it loads with results or with a bubble.

Parameters:
- DATA_W, 16, width of data, address, PC and instruction.
- NOP_INSTR, 16'h0800, instruction encoding used for bubbles and at reset.
- WAIT_MAX, 64, maximum cycles spent in WAIT before the timeout error.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- EXMem_DMemEn  in  1  memory access requested.
- EXMem_DMemWrite  in  1  1 = store, 0 = load (valid when DMemEn=1).
- EXMem_DMemDump  in  1  halt/dump request.
- EXMem_alu_result  in  DATA_W  effective address or ALU result.
- EXMem_rd_data2  in  DATA_W  store data.
- EXMem_MemToReg, EXMem_RegWrite  in  1 each  writeback controls.
- EXMem_WriteRegSel  in  3  destination register.
- EXMem_RegDst  in  2  passthrough.
- EXMem_new_PC, EXMem_instruction  in  DATA_W each  passthrough.
- mem_addr, mem_wdata  out  DATA_W each  memory request address and data.
- mem_rd, mem_wr, mem_createdump  out  1 each  single-cycle request strobes.
- mem_rdata  in  DATA_W  load data, valid with mem_done.
- mem_done  in  1  access complete.
- mem_busy  in  1  memory cannot accept a request this cycle.
- pipe_stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM.
- MemWB_alu_result, MemWB_mem_data, MemWB_new_PC, MemWB_instruction  out  DATA_W each  MEM/WB register outputs.
- MemWB_MemToReg, MemWB_RegWrite, MemWB_halt  out  1 each  MEM/WB register outputs.
- MemWB_WriteRegSel  out  3  MEM/WB register output.
- MemWB_RegDst  out  2  MEM/WB register output.
- err  out  1  sticky error: misaligned access or timeout.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst); every register is updated only on the clk rising edge.
- Reset values:
  - State = IDLE, wait counter = 0, err = 0.
  - All MemWB_* = 0, except MemWB_instruction = NOP_INSTR.
  - All strobes = 0, pipe_stall = 0.
- Derived signals: access = EXMem_DMemEn; misalign = access & EXMem_alu_result[0].
- mem_addr = EXMem_alu_result and mem_wdata = EXMem_rd_data2, both combinational.
- FSM states: IDLE, WAIT.
  - IDLE, no access: pipe_stall = 0. MEM/WB loads the EXMem bundle, with MemWB_mem_data = 0 and MemWB_halt = EXMem_DMemDump.
  - IDLE, EXMem_DMemDump = 1: mem_createdump pulses for this one cycle.
  - IDLE, misalign: no strobe is issued and err is set. MEM/WB loads a bubble: RegWrite = 0, MemToReg = 0, instruction = NOP_INSTR. pipe_stall = 0.
  - IDLE, access & !misalign & mem_busy: no strobe, pipe_stall = 1, MEM/WB loads a bubble, stay in IDLE.
  - IDLE, access & !misalign & !mem_busy: mem_rd = !DMemWrite and mem_wr = DMemWrite for exactly this cycle. pipe_stall = 1, MEM/WB loads a bubble, next state WAIT, counter cleared.
  - WAIT, mem_done = 0: no strobes, pipe_stall = 1, bubble into MEM/WB, counter increments.
  - WAIT, mem_done = 1: pipe_stall = 0 in the same cycle (combinational). MEM/WB loads the EXMem bundle with MemWB_mem_data = mem_rdata (loads) or 0 (stores). Next state IDLE.
  - WAIT, counter reaches WAIT_MAX-1 without mem_done: set err, bubble into MEM/WB, pipe_stall = 0, next state IDLE. The access is abandoned.
- Minimum memory-op latency: 2 cycles (issue cycle plus the done cycle). A non-memory instruction passes in 1 cycle.
- mem_done in IDLE is ignored: no state change and no data capture.
- Exactly one strobe is issued per instruction, never re-issued while WAIT holds the same EX/MEM contents.
- err is sticky until rst and does not stop the pipeline.
- rst asserted in WAIT: return to IDLE with all reset values. A late mem_done is ignored.
- EX/MEM keeps its contents whenever pipe_stall = 1; this block relies on that.

Decomposition:
- Shared package: FSM state encoding, NOP_INSTR, DATA_W, and the 3-bit register-select width.
- One natural sub-module: mem_wb_reg, a pure MEM/WB register with synchronous reset, load enable and bubble select.
- The FSM, counter and error logic stay in mem_stage.

Test Plan:
- ALU op (DMemEn = 0, RegWrite = 1, alu_result = 16'h1234, WriteRegSel = 3): next cycle MemWB_alu_result = 16'h1234, RegWrite = 1, no strobes, pipe_stall never high.
- Load from 16'h0040, memory returns 16'hBEEF with mem_done three cycles after mem_rd:
  - mem_rd high for exactly 1 cycle; pipe_stall high for 3 cycles.
  - MemWB_mem_data = 16'hBEEF and MemWB_MemToReg = 1 after the done edge.
  - Bubble instructions = 16'h0800 in between.
- Store to 16'h0042 with mem_busy held for 2 cycles: no mem_wr while busy, then mem_wr one cycle with mem_wdata = rd_data2; MemWB_RegWrite = 0 throughout.
- Misaligned load at 16'h0041: no mem_rd; err = 1 from the next cycle and stays 1; MemWB_RegWrite = 0; pipe_stall = 0.
- Timeout: mem_done never asserted after a load. Exactly WAIT_MAX cycles later, err = 1 and the FSM is back in IDLE; a subsequent ALU op passes normally.
- rst asserted mid-WAIT, then mem_done pulses one cycle later: all outputs are at reset values, MemWB_instruction = 16'h0800, and nothing is captured.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared widths, constants and FSM encoding for the memory stage slice.
package mem_stage_pkg;

   localparam int DATA_W   = 16;
   localparam int REGSEL_W = 3;
   localparam int REGDST_W = 2;
   localparam int WAIT_MAX = 64;

   localparam logic [DATA_W-1:0] NOP_INSTR = 16'h0800;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } mem_state_e;

endpackage

// File: rtl/mem_stage_wb_reg.sv
// MEM/WB pipeline register: loads either the incoming bundle or a bubble.
module mem_wb_reg
   import mem_stage_pkg::*;
#(
   parameter int                DATA_W    = mem_stage_pkg::DATA_W,
   parameter logic [DATA_W-1:0] NOP_INSTR = mem_stage_pkg::NOP_INSTR
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load_i,
   input  logic                bubble_i,
   input  logic [DATA_W-1:0]   aluResult_i,
   input  logic [DATA_W-1:0]   memData_i,
   input  logic [DATA_W-1:0]   newPc_i,
   input  logic [DATA_W-1:0]   instruction_i,
   input  logic                memToReg_i,
   input  logic                regWrite_i,
   input  logic                halt_i,
   input  logic [REGSEL_W-1:0] writeRegSel_i,
   input  logic [REGDST_W-1:0] regDst_i,
   output logic [DATA_W-1:0]   aluResult_o,
   output logic [DATA_W-1:0]   memData_o,
   output logic [DATA_W-1:0]   newPc_o,
   output logic [DATA_W-1:0]   instruction_o,
   output logic                memToReg_o,
   output logic                regWrite_o,
   output logic                halt_o,
   output logic [REGSEL_W-1:0] writeRegSel_o,
   output logic [REGDST_W-1:0] regDst_o
);

   logic [DATA_W-1:0]   aluResult_q;
   logic [DATA_W-1:0]   memData_q;
   logic [DATA_W-1:0]   newPc_q;
   logic [DATA_W-1:0]   instruction_q;
   logic                memToReg_q;
   logic                regWrite_q;
   logic                halt_q;
   logic [REGSEL_W-1:0] writeRegSel_q;
   logic [REGDST_W-1:0] regDst_q;

   // A bubble is a NOP with every side-effecting control cleared.
   always_ff @(posedge clk) begin
      if (rst || (load_i && bubble_i)) begin
         aluResult_q   <= '0;
         memData_q     <= '0;
         newPc_q       <= '0;
         instruction_q <= NOP_INSTR;
         memToReg_q    <= 1'b0;
         regWrite_q    <= 1'b0;
         halt_q        <= 1'b0;
         writeRegSel_q <= '0;
         regDst_q      <= '0;
      end else if (load_i) begin
         aluResult_q   <= aluResult_i;
         memData_q     <= memData_i;
         newPc_q       <= newPc_i;
         instruction_q <= instruction_i;
         memToReg_q    <= memToReg_i;
         regWrite_q    <= regWrite_i;
         halt_q        <= halt_i;
         writeRegSel_q <= writeRegSel_i;
         regDst_q      <= regDst_i;
      end
   end

   assign aluResult_o   = aluResult_q;
   assign memData_o     = memData_q;
   assign newPc_o       = newPc_q;
   assign instruction_o = instruction_q;
   assign memToReg_o    = memToReg_q;
   assign regWrite_o    = regWrite_q;
   assign halt_o        = halt_q;
   assign writeRegSel_o = writeRegSel_q;
   assign regDst_o      = regDst_q;

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues one data-memory request per instruction, stalls the
// upstream pipeline until mem_done, and feeds the MEM/WB register.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int                DATA_W    = mem_stage_pkg::DATA_W,
   parameter logic [DATA_W-1:0] NOP_INSTR = mem_stage_pkg::NOP_INSTR,
   parameter int                WAIT_MAX  = mem_stage_pkg::WAIT_MAX
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                EXMem_DMemEn,
   input  logic                EXMem_DMemWrite,
   input  logic                EXMem_DMemDump,
   input  logic [DATA_W-1:0]   EXMem_alu_result,
   input  logic [DATA_W-1:0]   EXMem_rd_data2,
   input  logic                EXMem_MemToReg,
   input  logic                EXMem_RegWrite,
   input  logic [REGSEL_W-1:0] EXMem_WriteRegSel,
   input  logic [REGDST_W-1:0] EXMem_RegDst,
   input  logic [DATA_W-1:0]   EXMem_new_PC,
   input  logic [DATA_W-1:0]   EXMem_instruction,
   output logic [DATA_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic                mem_rd,
   output logic                mem_wr,
   output logic                mem_createdump,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_done,
   input  logic                mem_busy,
   output logic                pipe_stall,
   output logic [DATA_W-1:0]   MemWB_alu_result,
   output logic [DATA_W-1:0]   MemWB_mem_data,
   output logic [DATA_W-1:0]   MemWB_new_PC,
   output logic [DATA_W-1:0]   MemWB_instruction,
   output logic                MemWB_MemToReg,
   output logic                MemWB_RegWrite,
   output logic                MemWB_halt,
   output logic [REGSEL_W-1:0] MemWB_WriteRegSel,
   output logic [REGDST_W-1:0] MemWB_RegDst,
   output logic                err
);

   localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

   mem_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;

   logic              access;
   logic              misalign;
   logic              rdStrobe;
   logic              wrStrobe;
   logic              dumpStrobe;
   logic              stall;
   logic              wbBubble;
   logic [DATA_W-1:0] wbMemData;

   assign access    = EXMem_DMemEn;
   assign misalign  = access & EXMem_alu_result[0];
   assign mem_addr  = EXMem_alu_result;
   assign mem_wdata = EXMem_rd_data2;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // The strobe fires only on the IDLE->WAIT transition, so a held EX/MEM
   // bundle can never re-issue while WAIT is outstanding.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      rdStrobe   = 1'b0;
      wrStrobe   = 1'b0;
      dumpStrobe = 1'b0;
      stall      = 1'b0;
      wbBubble   = 1'b1;
      wbMemData  = '0;
      case (state_q)
         ST_IDLE: begin
            dumpStrobe = EXMem_DMemDump;
            if (!access) begin
               wbBubble = 1'b0;
            end else if (misalign) begin
               err_d = 1'b1;
            end else if (mem_busy) begin
               stall = 1'b1;
            end else begin
               rdStrobe = ~EXMem_DMemWrite;
               wrStrobe = EXMem_DMemWrite;
               stall    = 1'b1;
               state_d  = ST_WAIT;
               cnt_d    = '0;
            end
         end
         ST_WAIT: begin
            if (mem_done) begin
               wbBubble  = 1'b0;
               wbMemData = EXMem_DMemWrite ? '0 : mem_rdata;
               state_d   = ST_IDLE;
            end else if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               stall = 1'b1;
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign mem_rd         = rdStrobe & ~rst;
   assign mem_wr         = wrStrobe & ~rst;
   assign mem_createdump = dumpStrobe & ~rst;
   assign pipe_stall     = stall & ~rst;
   assign err            = err_q;

   mem_wb_reg #(
      .DATA_W    (DATA_W),
      .NOP_INSTR (NOP_INSTR)
   ) u_mem_wb_reg (
      .clk           (clk),
      .rst           (rst),
      .load_i        (1'b1),
      .bubble_i      (wbBubble),
      .aluResult_i   (EXMem_alu_result),
      .memData_i     (wbMemData),
      .newPc_i       (EXMem_new_PC),
      .instruction_i (EXMem_instruction),
      .memToReg_i    (EXMem_MemToReg),
      .regWrite_i    (EXMem_RegWrite),
      .halt_i        (EXMem_DMemDump),
      .writeRegSel_i (EXMem_WriteRegSel),
      .regDst_i      (EXMem_RegDst),
      .aluResult_o   (MemWB_alu_result),
      .memData_o     (MemWB_mem_data),
      .newPc_o       (MemWB_new_PC),
      .instruction_o (MemWB_instruction),
      .memToReg_o    (MemWB_MemToReg),
      .regWrite_o    (MemWB_RegWrite),
      .halt_o        (MemWB_halt),
      .writeRegSel_o (MemWB_WriteRegSel),
      .regDst_o      (MemWB_RegDst)
   );

endmodule
